// File: rtl/clock_ctrl.sv
// Alarm clock core: minute/hour timekeeping from a tick strobe, button-driven
// field editing through a mode FSM, and an alarm that rings on a minute match.
module clock_ctrl #(
  parameter int TICKS_PER_MIN = 6000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tick_en,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       alarm_en,
  output logic [5:0] minute,
  output logic [4:0] hour,
  output logic [5:0] al_minute,
  output logic [4:0] al_hour,
  output logic [2:0] mode,
  output logic       min_tick,
  output logic       alarm
);
  localparam int PW = (TICKS_PER_MIN > 2) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICKS_PER_MIN - 1);

  typedef enum logic [2:0] {
    RUN         = 3'd0,
    SET_HOUR    = 3'd1,
    SET_MIN     = 3'd2,
    SET_AL_HOUR = 3'd3,
    SET_AL_MIN  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc;
  logic          mode_q, inc_q;
  logic          mode_press, inc_press, consume, act_mode, act_inc;
  logic          inc_hr, inc_mn, inc_al_hr, inc_al_mn;
  logic          advance;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] top);
    return (v >= top) ? 6'd0 : v + 6'd1;
  endfunction

  assign mode_press = btn_mode & ~mode_q;
  assign inc_press  = btn_inc & ~inc_q;
  // A ringing alarm swallows any press; a mode press shadows a coincident inc press.
  assign consume    = alarm & (mode_press | inc_press);
  assign act_mode   = mode_press & ~alarm;
  assign act_inc    = inc_press & ~alarm & ~mode_press;
  assign advance    = (state == RUN) && tick_en && (presc == PRESC_TOP);
  assign mode       = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (act_mode) begin
      case (state)
        RUN:         state_nxt = SET_HOUR;
        SET_HOUR:    state_nxt = SET_MIN;
        SET_MIN:     state_nxt = SET_AL_HOUR;
        SET_AL_HOUR: state_nxt = SET_AL_MIN;
        default:     state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    inc_hr    = act_inc && (state == SET_HOUR);
    inc_mn    = act_inc && (state == SET_MIN);
    inc_al_hr = act_inc && (state == SET_AL_HOUR);
    inc_al_mn = act_inc && (state == SET_AL_MIN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q    <= 1'b0;
      inc_q     <= 1'b0;
      presc     <= '0;
      minute    <= 6'd0;
      hour      <= 5'd0;
      al_minute <= 6'd0;
      al_hour   <= 5'd6;
      min_tick  <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      mode_q   <= btn_mode;
      inc_q    <= btn_inc;
      min_tick <= advance;

      if (state != RUN)    presc <= '0;
      else if (advance)    presc <= '0;
      else if (tick_en)    presc <= presc + 1'b1;

      if (advance) begin
        minute <= wrap_inc(minute, 6'd59);
        if (minute >= 6'd59) hour <= 5'(wrap_inc({1'b0, hour}, 6'd23));
      end else begin
        if (inc_mn) minute <= wrap_inc(minute, 6'd59);
        if (inc_hr) hour   <= 5'(wrap_inc({1'b0, hour}, 6'd23));
      end
      if (inc_al_mn) al_minute <= wrap_inc(al_minute, 6'd59);
      if (inc_al_hr) al_hour   <= 5'(wrap_inc({1'b0, al_hour}, 6'd23));

      // min_tick marks the cycle right after a timekeeping advance, so field edits never ring.
      if (!alarm_en)    alarm <= 1'b0;
      else if (consume) alarm <= 1'b0;
      else if (min_tick && (hour == al_hour) && (minute == al_minute)) alarm <= 1'b1;
    end
  end
endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: minute-count reference model plus
// directed literal checks and a randomized phase.
module tb_clock_ctrl;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rstn, tick_en, btn_mode, btn_inc, alarm_en;
  logic [5:0] minute, al_minute;
  logic [4:0] hour, al_hour;
  logic [2:0] mode;
  logic       min_tick, alarm;

  int total = 0;
  int bad   = 0;

  // Reference state: time and alarm held as minutes since midnight.
  int m_tm, m_al, m_mode, m_presc;
  bit m_mint, m_alarm, m_pm, m_pi;

  clock_ctrl #(.TICKS_PER_MIN(T)) dut (
    .clk(clk), .rstn(rstn), .tick_en(tick_en), .btn_mode(btn_mode),
    .btn_inc(btn_inc), .alarm_en(alarm_en), .minute(minute), .hour(hour),
    .al_minute(al_minute), .al_hour(al_hour), .mode(mode),
    .min_tick(min_tick), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_tm = 0; m_al = 6 * 60; m_mode = 0; m_presc = 0;
    m_mint = 0; m_alarm = 0; m_pm = 0; m_pi = 0;
  endtask

  task automatic model_step();
    bit pm, pi, o_alarm, o_mint;
    int o_tm, o_mode;
    if (!rstn) begin
      model_reset();
      return;
    end
    pm = btn_mode && !m_pm;
    pi = btn_inc && !m_pi;
    m_pm = btn_mode;
    m_pi = btn_inc;
    o_alarm = m_alarm; o_mint = m_mint; o_tm = m_tm; o_mode = m_mode;

    if (!alarm_en)                  m_alarm = 0;
    else if (o_alarm && (pm || pi)) m_alarm = 0;
    else if (o_mint && o_tm == m_al) m_alarm = 1;

    m_mint = 0;
    if (o_mode == 0) begin
      if (tick_en) begin
        m_presc++;
        if (m_presc == T) begin
          m_presc = 0;
          m_tm = (m_tm + 1) % 1440;
          m_mint = 1;
        end
      end
    end else begin
      m_presc = 0;
    end

    if (!o_alarm) begin
      if (pm) m_mode = (m_mode + 1) % 5;
      else if (pi) begin
        case (o_mode)
          1: m_tm = ((m_tm / 60 + 1) % 24) * 60 + m_tm % 60;
          2: m_tm = (m_tm / 60) * 60 + (m_tm % 60 + 1) % 60;
          3: m_al = ((m_al / 60 + 1) % 24) * 60 + m_al % 60;
          4: m_al = (m_al / 60) * 60 + (m_al % 60 + 1) % 60;
          default: ;
        endcase
      end
    end
  endtask

  // Inputs change 2 time units after the rising edge; the model advances on that edge.
  task automatic drive(input bit m, input bit i, input bit t);
    btn_mode = m; btn_inc = i; tick_en = t;
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic press_mode(); drive(1, 0, 0); drive(0, 0, 0); endtask
  task automatic press_inc();  drive(0, 1, 0); drive(0, 0, 0); endtask
  task automatic tick();       drive(0, 0, 1); drive(0, 0, 0); endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_minute"}, minute, 0);
    chk({tag, "_hour"}, hour, 0);
    chk({tag, "_al_minute"}, al_minute, 0);
    chk({tag, "_al_hour"}, al_hour, 6);
    chk({tag, "_mode"}, mode, 0);
    chk({tag, "_min_tick"}, min_tick, 0);
    chk({tag, "_alarm"}, alarm, 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_minute", minute, m_tm % 60);
      chk("cyc_hour", hour, m_tm / 60);
      chk("cyc_al_minute", al_minute, m_al % 60);
      chk("cyc_al_hour", al_hour, m_al / 60);
      chk("cyc_mode", mode, m_mode);
      chk("cyc_min_tick", min_tick, m_mint);
      chk("cyc_alarm", alarm, m_alarm);
    end
  end

  initial begin
    rstn = 1'b0; tick_en = 0; btn_mode = 0; btn_inc = 0; alarm_en = 1;
    model_reset();
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk_reset_values("rst");
    rstn = 1'b1;
    drive(0, 0, 0);

    // Set 23:59 and roll over to midnight.
    press_mode();
    repeat (23) press_inc();
    press_mode();
    repeat (59) press_inc();
    repeat (3) press_mode();
    chk("set_mode_run", mode, 0);
    chk("set_hour23", hour, 23);
    chk("set_min59", minute, 59);
    repeat (3) tick();
    chk("3tick_hour", hour, 23);
    chk("3tick_min", minute, 59);
    drive(0, 0, 1);
    chk("wrap_hour", hour, 0);
    chk("wrap_min", minute, 0);
    chk("wrap_tick", min_tick, 1);
    drive(0, 0, 0);
    chk("wrap_tick_off", min_tick, 0);

    // Field wrap without carry, ticks ignored while editing.
    press_mode();
    repeat (23) press_inc();
    press_inc();
    chk("hr_wrap", hour, 0);
    press_mode();
    repeat (59) press_inc();
    press_inc();
    chk("mn_wrap", minute, 0);
    chk("mn_wrap_hour", hour, 0);
    repeat (10) tick();
    chk("set_ticks_min", minute, 0);
    chk("set_ticks_hour", hour, 0);

    // Alarm at 06:00 from 05:59.
    repeat (4) press_mode();
    chk("back_set_hour", mode, 1);
    repeat (5) press_inc();
    press_mode();
    repeat (59) press_inc();
    repeat (3) press_mode();
    chk("pre_al_hour", hour, 5);
    chk("pre_al_min", minute, 59);
    repeat (3) tick();
    drive(0, 0, 1);
    chk("al_adv_hour", hour, 6);
    chk("al_adv_min", minute, 0);
    chk("al_not_yet", alarm, 0);
    drive(0, 0, 0);
    chk("al_ring", alarm, 1);
    drive(0, 1, 0);
    chk("al_cleared", alarm, 0);
    chk("al_clr_mode", mode, 0);
    chk("al_clr_hour", hour, 6);
    chk("al_clr_min", minute, 0);
    drive(0, 0, 0);

    // Simultaneous presses and a held mode button.
    press_mode();
    press_mode();
    chk("in_set_min", mode, 2);
    drive(1, 1, 0);
    chk("both_mode", mode, 3);
    chk("both_min", minute, 0);
    drive(0, 0, 0);
    repeat (5) drive(1, 0, 0);
    drive(0, 0, 0);
    chk("hold_mode", mode, 4);

    // Reset mid-edit in SET_AL_MIN.
    press_inc();
    press_inc();
    chk("al_min_edit", al_minute, 2);
    rstn = 1'b0;
    model_reset();
    #1;
    chk_reset_values("midrst");
    drive(0, 0, 0);
    rstn = 1'b1;
    drive(0, 0, 0);
    chk("post_rst_mode", mode, 0);

    // Randomized phase.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) alarm_en = ~alarm_en;
      if ($urandom_range(0, 499) == 0) begin
        rstn = 1'b0;
        model_reset();
        drive(0, 0, 0);
        rstn = 1'b1;
      end
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);
    end
    drive(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
